bus_memory_responder: RTL and testbench

//  Main-memory end of the cache<->memory block bus. It answers the cache controller's
//  bus_rd/bus_wr requests with 16-bit block data and a one-cycle bus_done pulse.
//  It holds 32 blocks x 16 bits, has a fixed programmable access latency, and checks
//  the protocol. It sits directly opposite the cache controller in the system top.

---
 rtl/cache_bus_pkg.sv | 19 +
 rtl/bus_memory_responder_mem_array.sv | 23 ++
 rtl/bus_memory_responder.sv | 136 +++++++++++++
 tb/tb_bus_memory_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_bus_pkg.sv
// Shared cache<->memory block bus definitions.
// States, request kinds and default widths.
package cache_bus_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    Q_IDLE = 3'b001,
    Q_BUSY = 3'b010,
    Q_DONE = 3'b100
  } state_t;

  typedef enum logic {
    KIND_RD = 1'b0,
    KIND_WR = 1'b1
  } kind_e;

endpackage

// File: rtl/bus_memory_responder_mem_array.sv
// Block store: synchronous write, asynchronous read.
// Contents undefined until written.
module mem_array #(
  parameter int    ADDR_W    = 5,
  parameter int    DATA_W    = 16,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/bus_memory_responder.sv
// Main-memory responder for the cache block bus.
// Fixed-latency read/write with protocol checking.
module bus_memory_responder
  import cache_bus_pkg::*;
#(
  parameter int    ADDR_W    = ADDR_W_DEF,
  parameter int    DATA_W    = DATA_W_DEF,
  parameter int    LATENCY   = 4,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_rd,
  input  logic              bus_wr,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_din,
  output logic [DATA_W-1:0] bus_dout,
  output logic              bus_done,
  output logic              busy,
  output logic              proto_err
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              rd_only, wr_only;
  logic              kind_ok, req_ok;
  logic              enter_done;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  mem_array #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_d),
    .wdata (din_d),
    .rdata (mem_rdata)
  );

  always_comb begin
    rd_only    = bus_rd & ~bus_wr;
    wr_only    = bus_wr & ~bus_rd;
    kind_ok    = (kind_q == KIND_RD) ? rd_only : wr_only;
    req_ok     = kind_ok & (bus_addr == addr_q) &
                 ((kind_q == KIND_RD) | (bus_din == din_q));
    state_d    = state_q;
    kind_d     = kind_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    din_d      = din_q;
    err_d      = err_q;
    enter_done = 1'b0;
    unique case (state_q)
      Q_IDLE: begin
        if (bus_rd & bus_wr) begin
          err_d = 1'b1;
        end else if (rd_only | wr_only) begin
          addr_d = bus_addr;
          din_d  = bus_din;
          kind_d = wr_only ? KIND_WR : KIND_RD;
          cnt_d  = CNT_INIT;
          if (LATENCY == 1) begin
            state_d    = Q_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = Q_BUSY;
          end
        end
      end
      Q_BUSY: begin
        // A dropped request is a legal cancel; any other change is an error.
        if (!bus_rd && !bus_wr) begin
          state_d = Q_IDLE;
        end else if (!req_ok) begin
          err_d   = 1'b1;
          state_d = Q_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d    = Q_DONE;
            enter_done = 1'b1;
          end
        end
      end
      Q_DONE:  state_d = Q_IDLE;
      default: state_d = Q_IDLE;
    endcase
    mem_we = enter_done & (kind_d == KIND_WR);
    done_d = enter_done;
    busy_d = (state_d != Q_IDLE);
    dout_d = (enter_done && kind_d == KIND_RD) ? mem_rdata : dout_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= Q_IDLE;
      kind_q  <= KIND_RD;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus_dout  = dout_q;
  assign bus_done  = done_q;
  assign busy      = busy_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench for bus_memory_responder.
// Table of transactions plus hand-written corner sequences.
module tb_bus_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd0, wr0, done0, busy0, err0;
  logic [4:0]  addr0;
  logic [15:0] din0, dout0;
  logic        rd1, wr1, done1, busy1, err1;
  logic [4:0]  addr1;
  logic [15:0] din1, dout1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_memory_responder #(.LATENCY(4)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .bus_rd    (rd0),
    .bus_wr    (wr0),
    .bus_addr  (addr0),
    .bus_din   (din0),
    .bus_dout  (dout0),
    .bus_done  (done0),
    .busy      (busy0),
    .proto_err (err0)
  );

  bus_memory_responder #(.LATENCY(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .bus_rd    (rd1),
    .bus_wr    (wr1),
    .bus_addr  (addr1),
    .bus_din   (din1),
    .bus_dout  (dout1),
    .bus_done  (done1),
    .busy      (busy1),
    .proto_err (err1)
  );

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [15:0] din;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pat(input logic [4:0] a);
    return {3'b000, a, 3'b000, a} ^ 16'h5A00;
  endfunction

  // Called just after a negedge; holds the request until done or timeout.
  task automatic txn(input logic wr, input logic [4:0] a,
                     input logic [15:0] d,
                     output int lat, output int bcnt);
    rd0 = ~wr; wr0 = wr; addr0 = a; din0 = d;
    lat = -1; bcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy0) bcnt++;
      if (done0) begin
        lat = k;
        break;
      end
    end
    rd0 = 1'b0; wr0 = 1'b0;
  endtask

  task automatic do_txn(input string nm, input logic wr,
                        input logic [4:0] a, input logic [15:0] d,
                        input int exp_lat, input logic [15:0] exp_dout);
    int lat, bcnt;
    txn(wr, a, d, lat, bcnt);
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " busy cycles"}, bcnt, 4);
    chk({nm, " dout"}, {16'h0, dout0}, {16'h0, exp_dout});
  endtask

  task automatic no_done(input string nm, input int n);
    int hits = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done0) hits++;
    end
    chk({nm, " no done"}, hits, 0);
  endtask

  task automatic gap(input string nm);
    @(negedge clk);
    chk({nm, " single pulse"}, {31'h0, done0}, 0);
  endtask

  task automatic sweep(input logic wr);
    int idx = 0;
    int last = -1;
    int bad_gap = 0;
    rd1 = ~wr; wr1 = wr; addr1 = 5'd0; din1 = pat(5'd0);
    for (int k = 1; k <= 200 && idx < 32; k++) begin
      @(negedge clk);
      if (done1) begin
        if (last < 0 && k != 1) bad_gap++;
        if (last >= 0 && k - last != 2) bad_gap++;
        last = k;
        if (!wr)
          chk($sformatf("sweep rd %0d", idx), {16'h0, dout1},
              {16'h0, pat(5'(idx))});
        idx++;
        addr1 = 5'(idx);
        din1  = pat(5'(idx));
      end
    end
    rd1 = 1'b0; wr1 = 1'b0;
    chk(wr ? "sweep wr count" : "sweep rd count", idx, 32);
    chk(wr ? "sweep wr spacing" : "sweep rd spacing", bad_gap, 0);
    @(negedge clk);
  endtask

  initial begin
    int lat, bcnt;
    vecs[0]  = '{1'b1, 5'd5,  16'hBEEF, 16'h0000};
    vecs[1]  = '{1'b0, 5'd5,  16'h0000, 16'hBEEF};
    vecs[2]  = '{1'b1, 5'd7,  16'h7777, 16'hBEEF};
    vecs[3]  = '{1'b1, 5'd9,  16'h0909, 16'hBEEF};
    vecs[4]  = '{1'b1, 5'd10, 16'h1010, 16'hBEEF};
    vecs[5]  = '{1'b1, 5'd11, 16'h0B0B, 16'hBEEF};
    vecs[6]  = '{1'b1, 5'd31, 16'hFFFF, 16'hBEEF};
    vecs[7]  = '{1'b1, 5'd0,  16'h0001, 16'hBEEF};
    vecs[8]  = '{1'b0, 5'd31, 16'h0000, 16'hFFFF};
    vecs[9]  = '{1'b0, 5'd0,  16'h0000, 16'h0001};
    vecs[10] = '{1'b0, 5'd7,  16'h0000, 16'h7777};
    vecs[11] = '{1'b0, 5'd10, 16'h0000, 16'h1010};

    reset = 1'b0;
    rd0 = 0; wr0 = 0; addr0 = '0; din0 = '0;
    rd1 = 0; wr1 = 0; addr1 = '0; din1 = '0;
    repeat (2) @(negedge clk);
    chk("rst done", {31'h0, done0}, 0);
    chk("rst dout", {16'h0, dout0}, 0);
    chk("rst busy", {31'h0, busy0}, 0);
    chk("rst err", {31'h0, err0}, 0);
    reset = 1'b1;
    @(negedge clk);

    sweep(1'b1);
    sweep(1'b0);

    for (int i = 0; i < 12; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr,
             vecs[i].din, 4, vecs[i].exp_dout);
      gap($sformatf("vec%0d", i));
    end

    // Write then read issued while the write is in its done cycle.
    do_txn("b2b wr", 1'b1, 5'd3, 16'h1234, 4, 16'h1010);
    do_txn("b2b rd", 1'b0, 5'd3, 16'h0000, 5, 16'h1234);
    gap("b2b");

    // Silent abort: request dropped in cycle 2.
    rd0 = 0; wr0 = 1; addr0 = 5'd7; din0 = 16'hAAAA;
    repeat (2) @(negedge clk);
    wr0 = 0;
    no_done("abort", 6);
    chk("abort err", {31'h0, err0}, 0);
    do_txn("abort rd7", 1'b0, 5'd7, 16'h0000, 4, 16'h7777);
    gap("abort rd7");

    // Address change while busy.
    rd0 = 0; wr0 = 1; addr0 = 5'd9; din0 = 16'h9999;
    repeat (2) @(negedge clk);
    addr0 = 5'd10;
    @(negedge clk);
    wr0 = 0;
    no_done("addrchg", 6);
    chk("addrchg err", {31'h0, err0}, 1);
    do_txn("addrchg rd9", 1'b0, 5'd9, 16'h0000, 4, 16'h0909);
    gap("addrchg rd9");
    do_txn("addrchg rd10", 1'b0, 5'd10, 16'h0000, 4, 16'h1010);
    gap("addrchg rd10");
    chk("err sticky", {31'h0, err0}, 1);

    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("err cleared", {31'h0, err0}, 0);
    @(negedge clk);

    // Both requests high at once.
    rd0 = 1; wr0 = 1; addr0 = 5'd5;
    no_done("both", 3);
    chk("both err", {31'h0, err0}, 1);
    chk("both busy", {31'h0, busy0}, 0);
    rd0 = 0; wr0 = 0;
    @(negedge clk);

    // Reset in cycle 2 of a write.
    rd0 = 0; wr0 = 1; addr0 = 5'd11; din0 = 16'hDEAD;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst done", {31'h0, done0}, 0);
    chk("midrst dout", {16'h0, dout0}, 0);
    chk("midrst busy", {31'h0, busy0}, 0);
    chk("midrst err", {31'h0, err0}, 0);
    @(negedge clk);
    reset = 1'b1;
    wr0 = 0;
    no_done("midrst", 5);
    txn(1'b0, 5'd11, 16'h0000, lat, bcnt);
    chk("midrst rd11 latency", lat, 4);
    chk("midrst rd11 dout", {16'h0, dout0}, 32'h0B0B);
    gap("midrst rd11");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
